// File: rtl/cordic_sincos_iter_pkg.sv
// cordic_sincos_pkg: types and constant helpers shared by cordic_sincos_iter.
// Holds the FSM state type, the arctangent table and gain generators, and the
// quadrant fold that maps first-quadrant results onto the full circle.
package cordic_sincos_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    // Fold operands are carried at a fixed width wide enough for WIDTH=32
    // after guard removal, so one helper serves every parameterisation.
    localparam int FOLD_W = 36;

    localparam real TWO_PI = 6.283185307179586;

    typedef struct packed {
        logic signed [FOLD_W-1:0] sin_val;
        logic signed [FOLD_W-1:0] cos_val;
    } fold_t;

    // 2^e as a real, for positive or negative e.
    function automatic real pow2(input int e);
        real p;
        p = 1.0;
        if (e >= 0) begin
            for (int k = 0; k < e; k++) p = p * 2.0;
        end else begin
            for (int k = 0; k < -e; k++) p = p / 2.0;
        end
        return p;
    endfunction

    // Arctangent of 2^-i, as a fraction of a full turn scaled by 2^frac_bits.
    function automatic longint atan_entry(input int i, input int frac_bits);
        return longint'($atan(pow2(-i)) / TWO_PI * pow2(frac_bits));
    endfunction

    // Inverse CORDIC gain over iters steps, scaled by 2^frac_bits.
    function automatic longint gain_init(input int iters, input int frac_bits);
        real k;
        k = 1.0;
        for (int i = 0; i < iters; i++) k = k / $sqrt(1.0 + pow2(-2 * i));
        return longint'(k * pow2(frac_bits));
    endfunction

    // Map first-quadrant (c, s) onto quadrant q.
    function automatic fold_t quad_fold(input logic [1:0] q,
                                        input logic signed [FOLD_W-1:0] c,
                                        input logic signed [FOLD_W-1:0] s);
        fold_t r;
        case (q)
            2'd0: begin r.cos_val = c;  r.sin_val = s;  end
            2'd1: begin r.cos_val = -s; r.sin_val = c;  end
            2'd2: begin r.cos_val = -c; r.sin_val = -s; end
            default: begin r.cos_val = s; r.sin_val = -c; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_sincos_iter_microrot.sv
// cordic_microrot: one combinational CORDIC rotation step. The direction is
// taken from the sign of the residual angle z.
module cordic_microrot #(
    parameter int IW = 20,
    parameter int SW = 4
) (
    input  logic signed [IW-1:0] x,
    input  logic signed [IW-1:0] y,
    input  logic signed [IW-1:0] z,
    input  logic [SW-1:0]        shift,
    input  logic signed [IW-1:0] atan,
    output logic signed [IW-1:0] x_next,
    output logic signed [IW-1:0] y_next,
    output logic signed [IW-1:0] z_next
);

    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;

    // Rotate towards z = 0 by +/- atan(2^-shift).
    always_comb begin
        x_sh = x >>> shift;
        y_sh = y >>> shift;
        if (!z[IW-1]) begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan;
        end else begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan;
        end
    end

endmodule

// File: rtl/cordic_sincos_iter.sv
// cordic_sincos_iter: handshaked iterative CORDIC sine/cosine, one
// micro-rotation per cycle, one result per ITERS+2 cycles.
// Build option CORDIC_SINCOS_ROUND_EN: when defined, guard bits are dropped
// with round-half-up; otherwise they are truncated toward -inf.
module cordic_sincos_iter
    import cordic_sincos_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH - 2,
    parameter int GUARD = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_angle,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sin,
    output logic [WIDTH-1:0] io_out_cos
);

    localparam int IW = WIDTH + GUARD + 1;   // one spare bit absorbs gain overshoot
    localparam int CW = $clog2(ITERS);
    localparam int TS = 1 << CW;             // table padded to the index range
    localparam int RW = WIDTH + 2;           // width after guard removal
    localparam logic signed [FOLD_W-1:0] LIM = FOLD_W'(2 ** (WIDTH - 2));

    state_t               state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [1:0]           q_reg;
    logic signed [IW-1:0] x_reg;
    logic signed [IW-1:0] y_reg;
    logic signed [IW-1:0] z_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic [WIDTH-1:0]     sin_reg;
    logic [WIDTH-1:0]     cos_reg;

    logic signed [IW-1:0] atan_tab [TS];
    logic signed [IW-1:0] x_init;
    logic signed [IW-1:0] x_next;
    logic signed [IW-1:0] y_next;
    logic signed [IW-1:0] z_next;
    logic signed [IW:0]   x_adj;
    logic signed [IW:0]   y_adj;
    logic signed [RW-1:0] c_val;
    logic signed [RW-1:0] s_val;
    fold_t                fold;

    // Arctangent table; entries past ITERS are never addressed.
    for (genvar gi = 0; gi < TS; gi++) begin : g_atan
        if (gi < ITERS) begin : g_used
            assign atan_tab[gi] = IW'(atan_entry(gi, WIDTH + GUARD));
        end else begin : g_pad
            assign atan_tab[gi] = '0;
        end
    end

    assign x_init = IW'(gain_init(ITERS, WIDTH - 2 + GUARD));

    cordic_microrot #(
        .IW (IW),
        .SW (CW)
    ) u_microrot (
        .x      (x_reg),
        .y      (y_reg),
        .z      (z_reg),
        .shift  (cnt_reg),
        .atan   (atan_tab[cnt_reg]),
        .x_next (x_next),
        .y_next (y_next),
        .z_next (z_next)
    );

    // Guard removal on the final rotation's outputs, one bit wider so the
    // rounding offset cannot overflow.
`ifdef CORDIC_SINCOS_ROUND_EN
    localparam int HALF = 1 << (GUARD - 1);
    assign x_adj = (IW+1)'(x_next) + (IW+1)'(HALF);
    assign y_adj = (IW+1)'(y_next) + (IW+1)'(HALF);
`else
    assign x_adj = (IW+1)'(x_next);
    assign y_adj = (IW+1)'(y_next);
`endif
    assign c_val = RW'(x_adj >>> GUARD);
    assign s_val = RW'(y_adj >>> GUARD);
    assign fold  = quad_fold(q_reg, FOLD_W'(c_val), FOLD_W'(s_val));

    function automatic logic [WIDTH-1:0] sat(input logic signed [FOLD_W-1:0] v);
        if (v > LIM) return WIDTH'(LIM);
        if (v < -LIM) return WIDTH'(-LIM);
        return WIDTH'(v);
    endfunction

    // Control FSM and datapath registers: accept, iterate, present result.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            q_reg         <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            sin_reg       <= '0;
            cos_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io_in_valid) begin
                        q_reg        <= io_in_angle[WIDTH-1:WIDTH-2];
                        z_reg        <= {{(IW - WIDTH + 2 - GUARD){1'b0}},
                                         io_in_angle[WIDTH-3:0], {GUARD{1'b0}}};
                        x_reg        <= x_init;
                        y_reg        <= '0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ROT;
                    end
                end
                ROT: begin
                    x_reg <= x_next;
                    y_reg <= y_next;
                    z_reg <= z_next;
                    if (cnt_reg == CW'(ITERS - 1)) begin
                        cnt_reg       <= '0;
                        sin_reg       <= sat(fold.sin_val);
                        cos_reg       <= sat(fold.cos_val);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (io_out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io_in_ready  = in_ready_reg;
    assign io_out_valid = out_valid_reg;
    assign io_out_sin   = sin_reg;
    assign io_out_cos   = cos_reg;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// tb_cordic_sincos_iter: directed and randomized stimulus for
// cordic_sincos_iter, checked every cycle against a real-arithmetic
// sin/cos model and a transaction-level handshake model.
module tb_cordic_sincos_iter;

    localparam int WIDTH = 16;
    localparam int ITERS = 14;
    localparam int LAT   = ITERS + 1;
`ifdef CORDIC_SINCOS_ROUND_EN
    localparam int TOL = 2;
`else
    localparam int TOL = 3;
`endif
    localparam real PI = 3.141592653589793;

    logic               clock = 1'b0;
    logic               reset;
    logic               io_in_valid;
    logic               io_in_ready;
    logic [WIDTH-1:0]   io_in_angle;
    logic               io_out_valid;
    logic               io_out_ready;
    logic signed [WIDTH-1:0] io_out_sin;
    logic signed [WIDTH-1:0] io_out_cos;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [WIDTH-1:0] ang;
        int               acc;
    } op_t;
    op_t pend[$];

    logic [WIDTH-1:0] edge_ang [6] = '{16'h3FFF, 16'h4001, 16'h7FFF,
                                       16'hBFFF, 16'hFFFF, 16'h0001};

    cordic_sincos_iter #(
        .WIDTH (WIDTH),
        .ITERS (ITERS),
        .GUARD (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_angle  (io_in_angle),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_sin   (io_out_sin),
        .io_out_cos   (io_out_cos)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Ideal sin/cos of the angle in turns, rounded to the output scale.
    function automatic void model(input logic [WIDTH-1:0] a, output int s, output int c);
        real th;
        th = 2.0 * PI * real'(a) / 65536.0;
        s = int'($sin(th) * 16384.0);
        c = int'($cos(th) * 16384.0);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        nvec++;
        if (d > tol || d < -tol) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d +/-%0d (cycle %0d)", nm, act, exp, tol, cyc);
        end
    endtask

    // Per-cycle compare against the transaction model.
    task automatic monitor();
        int  es;
        int  ec;
        bit  ev;
        op_t op;
        forever begin
            @(negedge clock);
            if (reset) begin
                pend.delete();
            end else begin
                chk("in_ready", int'(io_in_ready), int'(pend.size() == 0));
                ev = (pend.size() != 0) && (cyc - pend[0].acc >= LAT);
                chk("out_valid", int'(io_out_valid), int'(ev));
                if (io_out_valid && ev) begin
                    model(pend[0].ang, es, ec);
                    chk_tol("sin", int'(io_out_sin), es, TOL);
                    chk_tol("cos", int'(io_out_cos), ec, TOL);
                    if (io_out_ready) begin
                        $display("result angle=%h sin=%0d cos=%0d model=(%0d,%0d) cycle=%0d",
                                 pend[0].ang, io_out_sin, io_out_cos, es, ec, cyc);
                        void'(pend.pop_front());
                    end
                end
                if (io_in_valid && io_in_ready) begin
                    op.ang = io_in_angle;
                    op.acc = cyc;
                    pend.push_back(op);
                end
            end
        end
    endtask

    // Present one angle; returns the accept cycle, or -1 on timeout.
    task automatic send(input logic [WIDTH-1:0] a, output int acc);
        int n;
        n = 0;
        io_in_valid = 1'b1;
        io_in_angle = a;
        @(negedge clock);
        while (!io_in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("accept_in_time", int'(io_in_ready), 1);
        if (!io_in_ready) begin
            io_in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clock);
        #1;
        acc = cyc - 1;
        io_in_valid = 1'b0;
        io_in_angle = WIDTH'($urandom);
    endtask

    initial begin
        int es;
        int ec;
        int a0;
        int a1;
        int a2;
        int a3;
        int n;
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_angle  = '0;
        io_out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Pin the reference model with hand-computed values.
        model(16'h2000, es, ec);
        chk("model_sin45", es, 11585);
        chk("model_cos45", ec, 11585);
        model(16'h4000, es, ec);
        chk("model_sin90", es, 16384);
        chk("model_cos90", ec, 0);
        model(16'h8000, es, ec);
        chk("model_cos180", ec, -16384);
        model(16'hE000, es, ec);
        chk("model_sin315", es, -11585);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_sin", int'(io_out_sin), 0);
        chk("rst_cos", int'(io_out_cos), 0);
        chk("rst_out_valid", int'(io_out_valid), 0);
        chk("rst_in_ready", int'(io_in_ready), 1);
        @(posedge clock);
        #1;

        // Zero angle, then the three cardinal angles back-to-back.
        send(16'h0000, a0);
        send(16'h4000, a1);
        send(16'h8000, a2);
        send(16'hC000, a3);
        chk("b2b_gap1", a2 - a1, ITERS + 2);
        chk("b2b_gap2", a3 - a2, ITERS + 2);

        send(16'h2000, a0);
        send(16'hE000, a0);

        // Result held in DONE for 10 cycles with a competing input request.
        send(16'h1555, a0);
        io_out_ready = 1'b0;
        n = 0;
        while (!io_out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("hold_result_seen", int'(io_out_valid), 1);
        @(posedge clock);
        #1;
        io_in_valid = 1'b1;
        io_in_angle = 16'h7777;
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;

        // Reset during iteration 7 discards the operation.
        send(16'h3000, a0);
        repeat (7) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_sin", int'(io_out_sin), 0);
        chk("abort_cos", int'(io_out_cos), 0);
        chk("abort_out_valid", int'(io_out_valid), 0);
        chk("abort_in_ready", int'(io_in_ready), 1);
        @(posedge clock);
        #1;
        send(16'h0000, a0);

        // Quadrant-boundary angles.
        for (int k = 0; k < 6; k++) send(edge_ang[k], a0);

        // Random angles with random gaps and output stalls.
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            send(WIDTH'($urandom), a0);
            if ($urandom_range(0, 2) == 0) begin
                io_out_ready = 1'b0;
                repeat (LAT + $urandom_range(0, 5)) begin
                    @(posedge clock);
                    #1;
                end
                io_out_ready = 1'b1;
            end
        end

        n = 0;
        while (pend.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("drain", pend.size(), 0);
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
